// File: rtl/steer_en_gen.sv
// Rider-detect / steering-enable controller: registers load-cell samples, applies
// weight and balance thresholds, and enables steering after a balanced dwell.
module steer_en_gen #(
  parameter int unsigned       LD_W             = 12,
  parameter logic [LD_W-1:0]   MIN_RIDER_WEIGHT = 12'h200,
  parameter logic [LD_W-1:0]   HYST             = 12'h040,
  parameter int unsigned       ENTER_SHIFT      = 2,
  parameter int unsigned       EXIT_SHIFT       = 4,
  parameter int unsigned       TMR_CYCLES       = 65_000_000,
  parameter bit                FAST_SIM         = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic [LD_W-1:0] ld_cell_diff,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      steer_state
);

  localparam int unsigned SUM_W   = LD_W + 1;
  localparam int unsigned TMR_EFF = FAST_SIM ? 16 : TMR_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_EFF);

  localparam logic [SUM_W-1:0] ON_THR  = SUM_W'(MIN_RIDER_WEIGHT);
  localparam logic [SUM_W-1:0] OFF_THR = SUM_W'(MIN_RIDER_WEIGHT - HYST);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TMR_EFF - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    STEER_EN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  tmr_cnt, tmr_cnt_nxt;
  logic              en_steer_nxt, rider_off_nxt;

  logic [LD_W-1:0]   lft_q, rght_q;
  logic [SUM_W-1:0]  sum;
  logic [LD_W-1:0]   diff;
  logic              on, off, unbal, stepoff, tmr_full;

  // Input stage and registered difference magnitude
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_q        <= '0;
      rght_q       <= '0;
      ld_cell_diff <= '0;
    end else begin
      lft_q        <= lft_ld;
      rght_q       <= rght_ld;
      ld_cell_diff <= diff;
    end
  end

  // |lft-rght| always fits in LD_W bits, so order the subtraction instead of sign-extending
  always_comb begin
    sum  = SUM_W'(lft_q) + SUM_W'(rght_q);
    diff = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
  end

  assign on       = (sum > ON_THR);
  assign off      = (sum < OFF_THR);
  assign unbal    = (SUM_W'(diff) > (sum >> ENTER_SHIFT));
  assign stepoff  = (SUM_W'(diff) > (sum - (sum >> EXIT_SHIFT)));
  assign tmr_full = (tmr_cnt == TMR_MAX);

  // State, timer and Moore output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tmr_cnt   <= '0;
      en_steer  <= 1'b0;
      rider_off <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmr_cnt   <= tmr_cnt_nxt;
      en_steer  <= en_steer_nxt;
      rider_off <= rider_off_nxt;
    end
  end

  // Next state; off takes priority over every other condition
  always_comb begin
    state_nxt     = state;
    tmr_cnt_nxt   = '0;
    en_steer_nxt  = 1'b0;
    rider_off_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (on) state_nxt = WAIT;
      end
      WAIT: begin
        if (off)           state_nxt = IDLE;
        else if (unbal)    state_nxt = WAIT;
        else if (tmr_full) state_nxt = STEER_EN;
      end
      STEER_EN: begin
        if (off)          state_nxt = IDLE;
        else if (stepoff) state_nxt = WAIT;
      end
      default: state_nxt = IDLE;
    endcase

    // Timer only runs while staying in WAIT with balanced load; saturates at the top
    if ((state == WAIT) && (state_nxt == WAIT) && !unbal)
      tmr_cnt_nxt = tmr_full ? tmr_cnt : tmr_cnt + TMR_W'(1);

    en_steer_nxt  = (state_nxt == STEER_EN);
    rider_off_nxt = (state != IDLE) && (state_nxt == IDLE);
  end

  assign steer_state = state;

endmodule
